imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter n, default 8; byte-address width, so instruction memory holds N = 2^n bytes.
REQ-002 SHALL have parameter l, default 32; instruction width in bits, so there are l/8 = 4 bytes per word.
REQ-003 SHALL have port clk, input, 1 bit; the single clock, rising edge.
REQ-004 SHALL have port reset, input, 1 bit; asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit; a one-cycle pulse that begins a load session.
REQ-006 SHALL have port rx_data, input, 8 bits; the incoming byte stream.
REQ-007 SHALL have port rx_valid, input, 1 bit; rx_data is valid this cycle.
REQ-008 SHALL have port rx_ready, output, 1 bit; the loader accepts a byte this cycle.
REQ-009 SHALL have port mem_wr, output, 1 bit; byte write strobe to instruction memory.
REQ-010 SHALL have port mem_ad, output, n bits; byte write address.
REQ-011 SHALL have port mem_data, output, 8 bits; byte write data.
REQ-012 SHALL have port core_hold, output, 1 bit; holds the core in reset/stall until the image is valid.
REQ-013 SHALL have port done, output, 1 bit; level, set when the image is loaded and verified.
REQ-014 SHALL have port err, output, 1 bit; level, set on checksum mismatch.

Function
REQ-015 SHALL implement an FSM with states IDLE, LEN, DATA, CSUM, FILL, DONE and ERR.
REQ-016 SHALL accept a byte only on a cycle where rx_valid && rx_ready; rx_ready SHALL be 1 only in LEN, DATA and CSUM, and SHALL be combinational from state only.
REQ-017 SHALL, in IDLE, DONE or ERR, on start=1, clear the address counter and the checksum, clear done and err, set core_hold=1, and go to LEN; start SHALL be ignored in all other states.
REQ-018 SHALL, in LEN, take the accepted byte as the word count W; W=0 SHALL mean N/4 words. Byte count B = 4*W, limited to N. The checksum is initialised to the byte. Next state is DATA.
REQ-019 SHALL, in DATA, on each accepted byte, register mem_wr=1, mem_ad=addr and mem_data=byte for exactly the following cycle; addr SHALL increment modulo N and the checksum SHALL XOR in the byte; after B bytes the next state is CSUM.
REQ-020 SHALL, in CSUM, on the accepted byte: if the checksum XOR the byte is 0, go to FILL, or to DONE when addr has wrapped to 0 (full image); otherwise go to ERR.
REQ-021 SHALL, in FILL, write one byte per cycle without handshake: data 8'h13 when addr[1:0]==0, else 8'h00 (a NOP word). This SHALL continue until byte N-1 is written, then go to DONE.
REQ-022 SHALL, in DONE, hold done=1 and core_hold=0, one cycle after the last write strobe.
REQ-023 SHALL, in ERR, hold err=1 and core_hold=1, with no writes.
REQ-024 SHALL keep mem_wr=0 in every cycle except those defined in REQ-019 and REQ-021, so there is at most one write per cycle.
REQ-025 SHALL tolerate rx_valid gaps of any length; during a gap the state, addr and checksum SHALL hold.
REQ-026 SHALL set the address width to exactly n bits and let it wrap naturally from N-1 to 0.

Reset
REQ-027 SHALL, on reset=1 asynchronously, set state=IDLE, addr=0, checksum=0, mem_wr=0, mem_ad=0, mem_data=0, done=0, err=0 and core_hold=1.
REQ-028 SHALL, on reset mid-session, abandon the session with no further writes; a new start is required to load again.

Structure
REQ-029 SHALL define the FSM state encoding localparams, the NOP byte constant 8'h13, and the default n/l values in the shared core package, for reuse by the instruction-memory and core top levels.
REQ-030 SHALL be a single module; no sub-module is needed.
REQ-031 SHALL register all of mem_wr, mem_ad, mem_data, done, err and core_hold; only rx_ready SHALL be combinational.

Verification
REQ-032 SHALL test: start, then bytes 01, 93,00,10,00 and checksum 82 -> four writes at addresses 0-3 with data 93,00,10,00; then FILL writes 13,00,00,00 repeating over addresses 4-255; done=1; core_hold=0.
REQ-033 SHALL test: same stream with checksum 83 -> no writes after address 3; err=1; core_hold=1; a following start clears err.
REQ-034 SHALL test: len byte 00, 256 data bytes and a correct checksum -> 256 writes, FILL skipped, done=1 one cycle after the write to address 255.
REQ-035 SHALL test: rx_valid toggled 1/0 every cycle through DATA -> identical writes, spaced out, with no duplicates.
REQ-036 SHALL test: reset asserted after the third data byte -> mem_wr=0 immediately (asynchronous), IDLE, core_hold=1; start during DATA is ignored.
REQ-037 SHALL test: start pulsed in DONE -> done drops, core_hold=1, and a new session starts at address 0.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared constants for the instruction-memory loader, the instruction memory
// and the core top level.
package imem_loader_pkg;

  localparam int DEFAULT_N = 8;   // byte-address width
  localparam int DEFAULT_L = 32;  // instruction width in bits

  // Low byte of a NOP word (addi x0,x0,0 = 32'h0000_0013, little endian)
  localparam logic [7:0] NOP_BYTE = 8'h13;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LEN  = 3'd1;
  localparam logic [2:0] ST_DATA = 3'd2;
  localparam logic [2:0] ST_CSUM = 3'd3;
  localparam logic [2:0] ST_FILL = 3'd4;
  localparam logic [2:0] ST_DONE = 3'd5;
  localparam logic [2:0] ST_ERR  = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE = ST_IDLE,
    S_LEN  = ST_LEN,
    S_DATA = ST_DATA,
    S_CSUM = ST_CSUM,
    S_FILL = ST_FILL,
    S_DONE = ST_DONE,
    S_ERR  = ST_ERR
  } state_t;

endpackage

// File: rtl/imem_loader.sv
// Loads an instruction image from a byte stream into instruction memory,
// pads the rest of memory with NOP words, and releases the core once the
// XOR checksum over the length byte and data bytes matches.
//
// state | meaning
// IDLE  | no session since reset; core held
// LEN   | waiting for the word-count byte
// DATA  | writing received image bytes
// CSUM  | waiting for the checksum byte
// FILL  | padding remaining memory with NOP words, no handshake
// DONE  | image valid; core released
// ERR   | checksum mismatch; core held
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int n = DEFAULT_N,
  parameter int l = DEFAULT_L
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [7:0]   rx_data,
  input  logic         rx_valid,
  output logic         rx_ready,
  output logic         mem_wr,
  output logic [n-1:0] mem_ad,
  output logic [7:0]   mem_data,
  output logic         core_hold,
  output logic         done,
  output logic         err
);

  localparam int unsigned NBYTES = 1 << n;
  localparam int unsigned BPW    = l / 8;

  state_t       state, nxt;
  logic [n-1:0] addr;
  logic [7:0]   csum;
  logic [n:0]   rem;        // image bytes still expected in DATA
  logic         accept;
  logic         wr_d;
  logic [7:0]   wdata;
  logic         done_d;
  logic [31:0]  words;
  logic [31:0]  bytes_raw;
  logic [n:0]   len_bytes;

  assign rx_ready = (state == S_LEN) || (state == S_DATA) || (state == S_CSUM);
  assign accept   = rx_valid && rx_ready;

  // Byte count of the image: a zero word count means a full memory, and
  // anything larger than memory is clipped to it.
  always_comb begin
    words     = (rx_data == 8'd0) ? (NBYTES / BPW) : {24'd0, rx_data};
    bytes_raw = words * BPW;
    len_bytes = (bytes_raw > NBYTES) ? NBYTES[n:0] : bytes_raw[n:0];
  end

  // Next state, write request and status for the next cycle.
  always_comb begin
    nxt   = state;
    wr_d  = 1'b0;
    wdata = rx_data;
    case (state)
      S_IDLE, S_DONE, S_ERR: if (start) nxt = S_LEN;
      S_LEN:  if (accept) nxt = S_DATA;
      S_DATA: begin
        if (accept) begin
          wr_d = 1'b1;
          if (rem == (n+1)'(1)) nxt = S_CSUM;
        end
      end
      S_CSUM: begin
        if (accept) begin
          if ((csum ^ rx_data) != 8'd0) nxt = S_ERR;
          else if (addr == '0)          nxt = S_DONE;
          else                          nxt = S_FILL;
        end
      end
      S_FILL: begin
        wr_d  = 1'b1;
        wdata = (addr[1:0] == 2'd0) ? NOP_BYTE : 8'h00;
        if (addr == '1) nxt = S_DONE;
      end
      default: nxt = S_IDLE;
    endcase
    // done rises only once the final write strobe has been issued
    done_d = (nxt == S_DONE) && !wr_d;
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= nxt;
  end

  // Address, checksum, byte counter and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr      <= '0;
      csum      <= '0;
      rem       <= '0;
      mem_wr    <= 1'b0;
      mem_ad    <= '0;
      mem_data  <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      core_hold <= 1'b1;
    end else begin
      mem_wr    <= wr_d;
      done      <= done_d;
      err       <= (nxt == S_ERR);
      core_hold <= !done_d;
      if (wr_d) begin
        mem_ad   <= addr;
        mem_data <= wdata;
      end
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            addr <= '0;
            csum <= '0;
          end
        end
        S_LEN: begin
          if (accept) begin
            csum <= rx_data;
            rem  <= len_bytes;
          end
        end
        S_DATA: begin
          if (accept) begin
            addr <= addr + 1'b1;
            csum <= csum ^ rx_data;
            rem  <= rem - 1'b1;
          end
        end
        S_FILL:  addr <= addr + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table of load sessions plus
// hand-written reset / restart sequences. Expected writes go to a queue
// when bytes are driven and are popped by the write monitor.
module tb_imem_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       mem_wr;
  logic [7:0] mem_ad;
  logic [7:0] mem_data;
  logic       core_hold;
  logic       done;
  logic       err;

  imem_loader #(.n(8), .l(32)) dut (
    .clk(clk), .reset(reset), .start(start),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .mem_wr(mem_wr), .mem_ad(mem_ad), .mem_data(mem_data),
    .core_hold(core_hold), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] ad; logic [7:0] d; } wr_t;
  typedef struct {
    logic [7:0] len;
    bit         fixed;
    bit         bad;
    bit         gaps;
    int         mid_start;
    bit         exp_done;
  } row_t;

  wr_t        exp_q[$];
  row_t       rows[9];
  logic [7:0] fixed_data[4];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         last_wr_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Write monitor / scoreboard
  always @(negedge clk) begin
    if (mem_wr === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write actual ad=%0h data=%0h expected no write", mem_ad, mem_data);
      end else begin
        wr_t w;
        w = exp_q.pop_front();
        check("write_addr", {24'd0, mem_ad}, {24'd0, w.ad});
        check("write_data", {24'd0, mem_data}, {24'd0, w.d});
      end
      if (mem_ad == 8'hff) last_wr_cyc = cyc;
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int waits;
    if (gaps) begin
      @(negedge clk);
      rx_valid = 1'b0;
      rx_data  = 8'hA5;
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    waits = 0;
    while (!rx_ready && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    if (!rx_ready) begin
      checks++;
      errors++;
      $display("FAIL rx_ready_timeout actual=0 expected=1");
    end
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic run_session(input row_t r);
    logic [7:0] csum, b;
    int w, nb, ad, waits;
    pulse_start();
    check("start_done", {31'd0, done}, 32'd0);
    check("start_err", {31'd0, err}, 32'd0);
    check("start_hold", {31'd0, core_hold}, 32'd1);
    w  = (r.len == 8'd0) ? 64 : int'(r.len);
    nb = (w * 4 > 256) ? 256 : w * 4;
    send_byte(r.len, r.gaps);
    csum = r.len;
    ad   = 0;
    for (int i = 0; i < nb; i++) begin
      if (i == r.mid_start) pulse_start();
      b = r.fixed ? fixed_data[i % 4] : 8'($urandom);
      exp_q.push_back('{ad: 8'(ad), d: b});
      send_byte(b, r.gaps);
      csum ^= b;
      ad = (ad + 1) % 256;
    end
    send_byte(r.bad ? (csum ^ 8'h01) : csum, r.gaps);
    if (!r.bad) begin
      while (ad != 0) begin
        exp_q.push_back('{ad: 8'(ad), d: (ad % 4 == 0) ? 8'h13 : 8'h00});
        ad = (ad + 1) % 256;
      end
    end
    waits = 0;
    do begin
      @(negedge clk);
      waits++;
    end while (!(done || err) && waits < 600);
    if (waits >= 600) begin
      checks++;
      errors++;
      $display("FAIL session_timeout actual=no done/err expected=done or err");
    end
    if (r.exp_done && !r.gaps)
      check("done_latency", 32'(cyc - last_wr_cyc), 32'd1);
    repeat (4) @(negedge clk);
    check("end_done", {31'd0, done}, {31'd0, r.exp_done});
    check("end_err", {31'd0, err}, {31'd0, !r.exp_done});
    check("end_hold", {31'd0, core_hold}, {31'd0, !r.exp_done});
    check("queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1);
  end

  initial begin
    row_t r;
    fixed_data[0] = 8'h93; fixed_data[1] = 8'h00;
    fixed_data[2] = 8'h10; fixed_data[3] = 8'h00;
    //          len    fixed bad gaps mid exp_done
    rows[0] = '{8'h01, 1'b1, 1'b0, 1'b0, -1, 1'b1};  // 93,00,10,00 csum 82 + fill
    rows[1] = '{8'h01, 1'b1, 1'b1, 1'b0, -1, 1'b0};  // csum 83 -> err
    rows[2] = '{8'h00, 1'b0, 1'b0, 1'b0, -1, 1'b1};  // full image, no fill
    rows[3] = '{8'h01, 1'b1, 1'b0, 1'b1, -1, 1'b1};  // rx_valid toggling
    rows[4] = '{8'h50, 1'b0, 1'b0, 1'b0, -1, 1'b1};  // count clipped to memory
    rows[5] = '{8'h07, 1'b0, 1'b0, 1'b1, -1, 1'b1};
    rows[6] = '{8'h3F, 1'b0, 1'b1, 1'b1, -1, 1'b0};
    rows[7] = '{8'h02, 1'b0, 1'b0, 1'b0, -1, 1'b1};  // start after err
    rows[8] = '{8'h01, 1'b1, 1'b0, 1'b0,  2, 1'b1};  // start in DATA ignored

    reset = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
    check("rst_mem_ad", {24'd0, mem_ad}, 32'd0);
    check("rst_mem_data", {24'd0, mem_data}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_hold", {31'd0, core_hold}, 32'd1);
    check("rst_ready", {31'd0, rx_ready}, 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_ready", {31'd0, rx_ready}, 32'd0);

    for (int i = 0; i < 9; i++) begin
      r = rows[i];
      run_session(r);
    end

    // Reset after the third data byte abandons the session at once
    pulse_start();
    send_byte(8'h03, 1'b0);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back('{ad: 8'(i), d: 8'(8'h40 + i)});
      send_byte(8'(8'h40 + i), 1'b0);
    end
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_rst_mem_wr", {31'd0, mem_wr}, 32'd0);
    check("async_rst_hold", {31'd0, core_hold}, 32'd1);
    check("async_rst_ready", {31'd0, rx_ready}, 32'd0);
    check("async_rst_done", {31'd0, done}, 32'd0);
    check("async_rst_queue", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    rx_valid = 1'b1;
    rx_data  = 8'h77;
    repeat (6) @(negedge clk);
    rx_valid = 1'b0;
    check("post_rst_ready", {31'd0, rx_ready}, 32'd0);
    check("post_rst_hold", {31'd0, core_hold}, 32'd1);

    r = '{8'h02, 1'b0, 1'b0, 1'b0, -1, 1'b1};
    run_session(r);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
